// File: rtl/arc4_enc_if.sv
// Memory/handshake bundle between arc4_enc and its pt, ct and S memories.
// The top-level memory side is the master, and the encryptor is the slave.
interface arc4_enc_if;
    logic        en;
    logic        rdy;
    logic [23:0] key;
    logic [7:0]  pt_addr;
    logic [7:0]  pt_rddata;
    logic [7:0]  ct_addr;
    logic [7:0]  ct_wrdata;
    logic        ct_wren;
    logic [7:0]  s_addr;
    logic [7:0]  s_rddata;
    logic [7:0]  s_wrdata;
    logic        s_wren;

    modport master (
        output en, key, pt_rddata, s_rddata,
        input  rdy, pt_addr, ct_addr, ct_wrdata, ct_wren, s_addr, s_wrdata, s_wren
    );

    modport slave (
        input  en, key, pt_rddata, s_rddata,
        output rdy, pt_addr, ct_addr, ct_wrdata, ct_wren, s_addr, s_wrdata, s_wren
    );
endinterface

// File: rtl/arc4_enc.sv
// ARC4 encryptor: reads a length-prefixed pt message and writes a length-prefixed ct message.
// The S box is held in an external synchronous-read 256x8 memory.
module arc4_enc #(
    parameter int unsigned KEY_BYTES = 3
) (
    input logic       clk,
    input logic       rst_n,
    arc4_enc_if.slave bus
);

    typedef enum logic [3:0] {
        StIdle, StInit, StKsaRi, StKsaRj, StKsaWi, StKsaWj, StRdLen0, StRdLen1,
        StPrRi, StPrRj, StPrWi, StPrWj, StPrRp, StPrWc, StDone
    } state_e;

    state_e      r_state, w_state_d;
    logic [23:0] r_key;
    logic [7:0]  r_i, r_j, r_k, r_len, r_si, r_sj, r_pt;
    logic [1:0]  r_kidx;
    logic [7:0]  w_keybyte, w_i_inc, w_j_ksa, w_j_prga;

    always_comb begin
        case (r_kidx)
            2'd0:    w_keybyte = r_key[23:16];
            2'd1:    w_keybyte = r_key[15:8];
            default: w_keybyte = r_key[7:0];
        endcase
    end

    assign w_i_inc  = r_i + 8'd1;
    assign w_j_ksa  = r_j + bus.s_rddata + w_keybyte;
    assign w_j_prga = r_j + bus.s_rddata;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= StIdle;
        else        r_state <= w_state_d;
    end

    // Every read and write is a separate cycle, so no memory ever sees both in one cycle.
    always_comb begin
        w_state_d     = r_state;
        bus.rdy       = 1'b0;
        bus.pt_addr   = 8'd0;
        bus.ct_addr   = 8'd0;
        bus.ct_wrdata = 8'd0;
        bus.ct_wren   = 1'b0;
        bus.s_addr    = 8'd0;
        bus.s_wrdata  = 8'd0;
        bus.s_wren    = 1'b0;
        case (r_state)
            StIdle, StDone: begin
                bus.rdy   = 1'b1;
                w_state_d = bus.en ? StInit : StIdle;
            end
            StInit: begin
                bus.s_addr   = r_i;
                bus.s_wrdata = r_i;
                bus.s_wren   = 1'b1;
                if (r_i == 8'd255) w_state_d = StKsaRi;
            end
            StKsaRi: begin
                bus.s_addr = r_i;
                w_state_d  = StKsaRj;
            end
            StKsaRj: begin
                bus.s_addr = w_j_ksa;
                w_state_d  = StKsaWi;
            end
            StKsaWi: begin
                bus.s_addr   = r_i;
                bus.s_wrdata = bus.s_rddata;
                bus.s_wren   = 1'b1;
                w_state_d    = StKsaWj;
            end
            StKsaWj: begin
                // Written last, so when i==j the slot ends up holding its original value.
                bus.s_addr   = r_j;
                bus.s_wrdata = r_si;
                bus.s_wren   = 1'b1;
                w_state_d    = (r_i == 8'd255) ? StRdLen0 : StKsaRi;
            end
            StRdLen0: begin
                bus.pt_addr = 8'd0;
                w_state_d   = StRdLen1;
            end
            StRdLen1: begin
                bus.ct_addr   = 8'd0;
                bus.ct_wrdata = bus.pt_rddata;
                bus.ct_wren   = 1'b1;
                w_state_d     = (bus.pt_rddata == 8'd0) ? StDone : StPrRi;
            end
            StPrRi: begin
                bus.s_addr  = w_i_inc;
                bus.pt_addr = r_k;
                w_state_d   = StPrRj;
            end
            StPrRj: begin
                bus.s_addr = w_j_prga;
                w_state_d  = StPrWi;
            end
            StPrWi: begin
                bus.s_addr   = r_i;
                bus.s_wrdata = bus.s_rddata;
                bus.s_wren   = 1'b1;
                w_state_d    = StPrWj;
            end
            StPrWj: begin
                bus.s_addr   = r_j;
                bus.s_wrdata = r_si;
                bus.s_wren   = 1'b1;
                w_state_d    = StPrRp;
            end
            StPrRp: begin
                bus.s_addr = r_si + r_sj;
                w_state_d  = StPrWc;
            end
            StPrWc: begin
                bus.ct_addr   = r_k;
                bus.ct_wrdata = bus.s_rddata ^ r_pt;
                bus.ct_wren   = 1'b1;
                w_state_d     = (r_k == r_len) ? StDone : StPrRi;
            end
            default: w_state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_key  <= 24'd0;
            r_i    <= 8'd0;
            r_j    <= 8'd0;
            r_k    <= 8'd0;
            r_len  <= 8'd0;
            r_si   <= 8'd0;
            r_sj   <= 8'd0;
            r_pt   <= 8'd0;
            r_kidx <= 2'd0;
        end else begin
            case (r_state)
                StIdle, StDone: begin
                    if (bus.en) begin
                        r_key  <= bus.key;
                        r_i    <= 8'd0;
                        r_j    <= 8'd0;
                        r_k    <= 8'd0;
                        r_kidx <= 2'd0;
                    end
                end
                StInit: r_i <= w_i_inc;
                StKsaRj: begin
                    r_si <= bus.s_rddata;
                    r_j  <= w_j_ksa;
                end
                StKsaWj: begin
                    r_i    <= w_i_inc;
                    r_kidx <= (r_kidx == 2'(KEY_BYTES - 1)) ? 2'd0 : r_kidx + 2'd1;
                end
                StRdLen1: begin
                    r_len <= bus.pt_rddata;
                    r_i   <= 8'd0;
                    r_j   <= 8'd0;
                    r_k   <= 8'd1;
                end
                StPrRi: r_i <= w_i_inc;
                StPrRj: begin
                    r_si <= bus.s_rddata;
                    r_j  <= w_j_prga;
                    r_pt <= bus.pt_rddata;
                end
                StPrWi: r_sj <= bus.s_rddata;
                StPrWc: r_k  <= r_k + 8'd1;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_arc4_enc.sv
// Scoreboard bench for arc4_enc: expected ct writes are queued, and a negedge monitor checks them.
module tb_arc4_enc;
    typedef struct packed { logic [7:0] addr; logic [7:0] data; } wr_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    arc4_enc_if bus ();
    arc4_enc #(.KEY_BYTES(3)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    logic [7:0] pt_mem [256];
    logic [7:0] ct_mem [256];
    logic [7:0] s_mem  [256];
    logic [7:0] m_s_ksa [256];
    logic [7:0] m_ks [256];

    always @(posedge clk) begin
        bus.pt_rddata <= pt_mem[bus.pt_addr];
        bus.s_rddata  <= s_mem[bus.s_addr];
        if (bus.s_wren)  s_mem[bus.s_addr]   <= bus.s_wrdata;
        if (bus.ct_wren) ct_mem[bus.ct_addr] <= bus.ct_wrdata;
    end

    wr_t sb_q[$];
    int  n_checks = 0, n_errors = 0;
    int  cyc = 0, last_ct_cyc = 0;
    int  n_any_wr = 0, n_rst_wr = 0, n_ct0 = 0, n_ct_wr = 0;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        wr_t e;
        if (!rst_n) begin
            if (bus.ct_wren || bus.s_wren) n_rst_wr++;
        end else begin
            if (bus.ct_wren || bus.s_wren) n_any_wr++;
            if (bus.ct_wren) begin
                n_ct_wr++;
                last_ct_cyc = cyc;
                if (bus.ct_addr == 8'd0) n_ct0++;
                n_checks++;
                if (sb_q.size() == 0) begin
                    n_errors++;
                    $display("FAIL ct_unexpected: got addr=%0d data=%02h, expected no write",
                             bus.ct_addr, bus.ct_wrdata);
                end else begin
                    e = sb_q.pop_front();
                    if (bus.ct_addr != e.addr || bus.ct_wrdata != e.data) begin
                        n_errors++;
                        $display("FAIL ct_write: got addr=%0d data=%02h, expected addr=%0d data=%02h",
                                 bus.ct_addr, bus.ct_wrdata, e.addr, e.data);
                    end
                end
            end
        end
    end

    task automatic check(input string name, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, got, got, exp, exp);
        end
    endtask

    // Plain software ARC4: S after KSA and the first len keystream bytes.
    task automatic model_ks(input logic [23:0] key, input int len);
        logic [7:0] s [256];
        logic [7:0] kb [3];
        logic [7:0] i, j, t;
        kb[0] = key[23:16]; kb[1] = key[15:8]; kb[2] = key[7:0];
        for (int n = 0; n < 256; n++) s[n] = 8'(n);
        j = 8'd0;
        for (int n = 0; n < 256; n++) begin
            j = j + s[n] + kb[n % 3];
            t = s[n]; s[n] = s[j]; s[j] = t;
        end
        m_s_ksa = s;
        i = 8'd0; j = 8'd0;
        for (int k = 1; k <= len; k++) begin
            i = i + 8'd1;
            j = j + s[i];
            t = s[i]; s[i] = s[j]; s[j] = t;
            m_ks[k] = s[8'(s[i] + s[j])];
        end
    endtask

    task automatic push_model(input int len);
        sb_q.push_back({8'd0, 8'(len)});
        for (int k = 1; k <= len; k++) sb_q.push_back({8'(k), pt_mem[k] ^ m_ks[k]});
    endtask

    task automatic start_op(input logic [23:0] key);
        @(negedge clk);
        bus.key = key;
        bus.en  = 1'b1;
        @(negedge clk);
        bus.en  = 1'b0;
        check("rdy_low_after_start", int'(bus.rdy), 0);
    endtask

    task automatic wait_done(input string name);
        int n = 0;
        while (!bus.rdy && n < 6000) begin
            @(negedge clk);
            n++;
        end
        n_checks++;
        if (!bus.rdy) begin
            n_errors++;
            $display("FAIL %s_timeout: rdy still 0 after %0d cycles, expected 1", name, n);
        end
        check({name, "_rdy_latency"}, cyc - last_ct_cyc, 1);
        check({name, "_queue_drained"}, sb_q.size(), 0);
    endtask

    task automatic load_vec2();
        logic [7:0] msg [10];
        msg = '{8'd9, 8'h50, 8'h6C, 8'h61, 8'h69, 8'h6E, 8'h74, 8'h65, 8'h78, 8'h74};
        for (int n = 0; n < 10; n++) pt_mem[n] = msg[n];
    endtask

    task automatic push_vec2();
        logic [7:0] exp [10];
        exp = '{8'h09, 8'hBB, 8'hF3, 8'h16, 8'hE8, 8'hD9, 8'h40, 8'hAF, 8'h0A, 8'hD3};
        for (int n = 0; n < 10; n++) sb_q.push_back({8'(n), exp[n]});
    endtask

    initial begin
        int bad;
        bus.en  = 1'b0;
        bus.key = 24'd0;
        for (int n = 0; n < 256; n++) begin
            pt_mem[n] = 8'd0; ct_mem[n] = 8'd0; s_mem[n] = 8'd0;
        end

        // 1: reset and idle
        repeat (3) @(negedge clk);
        check("rst_rdy", int'(bus.rdy), 1);
        check("rst_ct_wren", int'(bus.ct_wren), 0);
        check("rst_s_wren", int'(bus.s_wren), 0);
        check("rst_s_addr", int'(bus.s_addr), 0);
        rst_n = 1'b1;
        repeat (100) @(negedge clk);
        check("idle_no_writes", n_any_wr, 0);
        check("idle_rdy", int'(bus.rdy), 1);

        // 2: known vector
        load_vec2();
        push_vec2();
        start_op(24'h4B6579);
        wait_done("vec2");

        // 3: zero length
        pt_mem[0] = 8'd0;
        for (int n = 0; n < 256; n++) ct_mem[n] = 8'hEE;
        model_ks(24'h000018, 0);
        n_ct_wr = 0;
        push_model(0);
        start_op(24'h000018);
        wait_done("zero");
        check("zero_ct_writes", n_ct_wr, 1);
        check("zero_ct0", int'(ct_mem[0]), 0);
        bad = 0;
        for (int n = 1; n < 256; n++) if (ct_mem[n] != 8'hEE) bad++;
        check("zero_ct_untouched", bad, 0);
        bad = 0;
        for (int n = 0; n < 256; n++) if (s_mem[n] != m_s_ksa[n]) bad++;
        check("zero_s_permuted", bad, 0);

        // 4: loopback with a 255-byte message
        pt_mem[0] = 8'd255;
        for (int n = 1; n < 256; n++) pt_mem[n] = 8'($urandom_range(0, 255));
        model_ks(24'h000018, 255);
        push_model(255);
        start_op(24'h000018);
        wait_done("loop");
        check("loop_ct0", int'(ct_mem[0]), 255);
        bad = 0;
        for (int k = 1; k < 256; k++) if ((ct_mem[k] ^ m_ks[k]) != pt_mem[k]) bad++;
        check("loop_decrypt", bad, 0);

        // 5: en pulses during PRGA are ignored
        pt_mem[0] = 8'd5;
        model_ks(24'h000018, 5);
        push_model(5);
        n_ct0 = 0;
        start_op(24'h000018);
        for (int n = 0; n < 2000 && n_ct0 == 0; n++) @(negedge clk);
        for (int n = 0; n < 15; n++) begin
            bus.en = 1'b1; @(negedge clk);
            bus.en = 1'b0; @(negedge clk);
        end
        wait_done("pulse");
        repeat (5) @(negedge clk);
        check("pulse_single_ct0", n_ct0, 1);
        check("pulse_stays_idle", int'(bus.rdy), 1);

        // 5b: en held high back-to-back
        push_model(5);
        push_model(5);
        n_ct0 = 0;
        @(negedge clk);
        bus.key = 24'h000018;
        bus.en  = 1'b1;
        @(negedge clk);
        check("held_first_start", int'(bus.rdy), 0);
        for (int n = 0; n < 6000 && !bus.rdy; n++) @(negedge clk);
        check("held_first_done", int'(bus.rdy), 1);
        @(negedge clk);
        check("held_second_start", int'(bus.rdy), 0);
        bus.en = 1'b0;
        wait_done("held");
        check("held_two_ct0", n_ct0, 2);

        // 6: abort mid-KSA, then rerun the known vector
        load_vec2();
        push_vec2();
        n_ct_wr = 0;
        start_op(24'h4B6579);
        repeat (400) @(negedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        sb_q.delete();
        n_rst_wr = 0;
        repeat (4) begin
            @(negedge clk);
            check("abort_rdy_in_reset", int'(bus.rdy), 1);
        end
        check("abort_no_writes_in_reset", n_rst_wr, 0);
        check("abort_no_ct_before", n_ct_wr, 0);
        @(posedge clk);
        #2 rst_n = 1'b1;
        push_vec2();
        start_op(24'h4B6579);
        wait_done("rerun");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule

// File: doc/arc4_enc.md
Name: arc4_enc

Overview:
ARC4 encryptor, the write-direction counterpart of the arc4 decryption core.
- Reads a length-prefixed plaintext message from pt memory.
- Runs ARC4 init, KSA and PRGA using an external 256x8 S memory.
- Writes the length-prefixed ciphertext into ct memory.
- Sits in the top level beside ct_mem, pt_mem and s_mem. Same en/rdy handshake as arc4, so the top can run encrypt then decrypt for loopback.

Parameters:
- KEY_BYTES, 3, number of key bytes taken from key[23:0] (fixed 3; key byte n = key[23-8n -: 8], MSB byte first)

Ports:
- clk  input  1  system clock, all state on rising edge
- rst_n  input  1  asynchronous active-low reset
- en  input  1  start request, sampled only while rdy=1
- rdy  output  1  1 = idle and able to accept en
- key  input  24  ARC4 key, sampled on the accepted en cycle
- pt_addr  output  8  plaintext memory address
- pt_rddata  input  8  plaintext read data, valid 1 cycle after pt_addr
- ct_addr  output  8  ciphertext memory address
- ct_wrdata  output  8  ciphertext write data
- ct_wren  output  1  ciphertext write enable
- s_addr  output  8  S memory address
- s_rddata  input  8  S read data, valid 1 cycle after s_addr
- s_wrdata  output  8  S write data
- s_wren  output  1  S write enable

Behaviour:
- Reset values (async on rst_n=0): rdy=1; ct_wren=0; s_wren=0; all addresses and wrdata=0; i=j=k=0; state IDLE.
- Reset mid-operation aborts immediately. No further writes occur. Memory contents are left as-is.
- All memories are synchronous-read. Address is presented in cycle t and data is used in cycle t+1. Reads and writes never overlap on the same memory in the same cycle.
- Handshake:
  - en=1 with rdy=1 latches key and starts the operation; rdy=0 from the next cycle.
  - en while rdy=0 is ignored.
  - rdy returns to 1 one cycle after the final ct write.
  - en held high re-triggers a new operation.
- States: IDLE -> INIT -> KSA -> RDLEN -> PRGA -> DONE -> IDLE.
- INIT: write s[n]=n for n=0..255, one write per cycle, 256 cycles. The counter wraps 255 -> 0 and exits.
- KSA: j=0. For i=0..255:
  - j = j + s[i] + keybyte[i mod 3], all mod 256.
  - swap s[i], s[j].
  - Each iteration uses a read s[i], a read s[j], a write s[i]<=old s[j], and a write s[j]<=old s[i].
  - i==j is legal. The final value of s[i] must equal its original value, so the write order must not corrupt it.
- RDLEN: read pt[0] into L (8 bits, 0..255). Write ct[0]=L.
  - L=0: go straight to DONE with no further writes.
- PRGA: i=j=0. For k=1..L:
  - i=i+1; j=j+s[i]; swap s[i], s[j].
  - pad = s[(s[i]+s[j]) mod 256], using post-swap values.
  - Read pt[k], then write ct[k] = pad ^ pt[k].
  - Exactly one ct write per byte. ct_addr=k, with no address wrap since k<=255.
- Arithmetic: all index sums are 8-bit and wrap modulo 256.
- ct_wren and s_wren are single-cycle pulses, only asserted while the matching address/data are valid. pt memory is never written.
- Per-byte PRGA latency is implementation-defined, but the whole operation must complete within 256 + 256*6 + 4 + 255*10 cycles.

Test Plan:
1. Reset then idle: rst_n low then high -> rdy=1, ct_wren=0, s_wren=0; en held 0 for 100 cycles -> no memory writes.
2. Known vector: key=24'h4B6579 ("Key"), pt = {9,"Plaintext"}, pulse en -> ct[0]=8'h09, ct[1..9]=BB F3 16 E8 D9 40 AF 0A D3; rdy returns to 1.
3. Zero length: pt[0]=0, key=24'h000018 -> exactly one ct write (ct[0]=0), S initialized/permuted, rdy returns to 1, ct[1..255] untouched.
4. Loopback: key=24'h000018, random 255-byte message -> arc4 decryption of the produced ct reproduces pt[1..255] byte-exact.
5. Handshake: en pulsed repeatedly during PRGA -> ignored, single ct[0] write; en held high -> second full operation begins one cycle after rdy rises, same ct output.
6. Abort: assert rst_n=0 mid-KSA, then re-run vector 2 -> rdy=1 during reset, no writes while in reset, second run output equals vector 2 exactly.
